// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root family: FSM states and iteration sizing.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int ITER      = WIDTH_DEF;
    localparam int CNT_W     = (ITER > 1) ? $clog2(ITER) : 1;

    // Iterations needed for a radicand width: one multiplier bit per cycle.
    function automatic int iter_count(input int width);
        return width;
    endfunction

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/square_recon_step.sv
// One shift-add step of the serial root*root multiply: adds root<<shamt when the bit is set.
module square_recon_step
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic [2*WIDTH:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic             mbit,
    input  logic [CW-1:0]    shamt,
    output logic [2*WIDTH:0] acc_next
);

    localparam int ACC_W = 2 * WIDTH + 1;

    logic [ACC_W-1:0] addend;

    always_comb begin
        addend   = {{(WIDTH + 1){1'b0}}, mcand} << shamt;
        acc_next = mbit ? (acc + addend) : acc;
    end

endmodule

// File: rtl/square_recon.sv
// Serial reconstruction of a radicand from (root, rem): rad = (root*root + rem) >> FBITS.
module square_recon
    import sqrt_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FBITS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] root,
    input  logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] rad,
    output logic             ovf,
    output logic             exact,
    output logic             rem_ok
);

    localparam int ITER_N = iter_count(WIDTH);
    localparam int CW     = cnt_width(WIDTH);
    localparam int ACC_W  = 2 * WIDTH + 1;
    localparam logic [ACC_W-1:0] FMASK = (ACC_W'(1) << FBITS) - ACC_W'(1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] root_q;
    logic [WIDTH-1:0] rem_q;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W-1:0] scaled;
    logic             last_step;

    square_recon_step #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_step (
        .acc      (acc),
        .mcand    (root_q),
        .mbit     (root_q[cnt]),
        .shamt    (cnt),
        .acc_next (acc_next)
    );

    assign scaled    = acc_next >> FBITS;
    assign last_step = (state == RUN) && (cnt == CW'(ITER_N - 1));

    // Operand capture and accumulator carry no reset; they are only observed through DONE.
    always_ff @(posedge clk) begin
        if (start && !reset) begin
            root_q <= root;
            rem_q  <= rem;
            acc    <= {{(WIDTH + 1){1'b0}}, rem};
        end else if (state == RUN) begin
            acc <= acc_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            rad    <= '0;
            ovf    <= 1'b0;
            exact  <= 1'b0;
            rem_ok <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                state <= RUN;
                cnt   <= '0;
                busy  <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        cnt <= cnt + 1'b1;
                        if (last_step) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            valid  <= 1'b1;
                            rad    <= scaled[WIDTH-1:0];
                            ovf    <= |scaled[ACC_W-1:WIDTH];
                            exact  <= ((acc_next & FMASK) == '0);
                            rem_ok <= ({1'b0, rem_q} <= {root_q, 1'b0});
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
